// File: rtl/mirfak_fetch_unit_pkg.sv
// Shared types and constants for the Mirfak instruction fetch stage.
package mirfak_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
    localparam logic [3:0]  XCAUSE_MISALIGNED   = 4'd0;
    localparam logic [3:0]  XCAUSE_ACCESS_FAULT = 4'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DISCARD,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  cause;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic        exc,
        input logic [3:0]  cause
    );
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.exc   = exc;
        e.cause = cause;
        return e;
    endfunction

endpackage

// File: rtl/mirfak_fetch_skid.sv
// One-entry skid buffer that catches a fetched entry while the IF/ID register is stalled.
module mirfak_fetch_skid
    import mirfak_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t incoming,
    output logic         full,
    output fetch_entry_t held
);

    // A push in the same cycle as a pop replaces the departing entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            held <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            held <= incoming;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mirfak_fetch_unit.sv
// Mirfak RV32IM instruction fetch: owns the PC, issues single-outstanding Wishbone reads
// and feeds the IF/ID register, with a one-entry skid absorbing decode stalls.
module mirfak_fetch_unit
    import mirfak_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    input  logic        if_redirect_i,
    input  logic [31:0] if_redirect_pc_i,
    input  logic        id_stall_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instruction_o,
    output logic        id_valid_o,
    output logic        id_exception_o,
    output logic [3:0]  id_xcause_o
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  bus_addr;
    logic         bus_cyc;
    logic         bus_done;
    logic         misaligned_start;
    logic         id_ready;
    logic         new_valid;
    fetch_entry_t new_entry;
    logic         skid_full;
    logic         skid_push;
    logic         skid_pop;
    fetch_entry_t skid_entry;
    fetch_entry_t id_next;

    assign iwbm_addr_o = bus_addr;
    assign iwbm_cyc_o  = bus_cyc;
    assign iwbm_stb_o  = bus_cyc;

    assign bus_done         = iwbm_ack_i | iwbm_err_i;
    assign id_ready         = !id_valid_o || !id_stall_i;
    assign misaligned_start = (state == S_IDLE) && !skid_full && (fetch_pc[1:0] != 2'b00);

    // The entry produced this cycle: a bus response, a bus fault, or a misaligned-PC fault.
    always_comb begin
        new_valid = 1'b0;
        new_entry = make_entry(fetch_pc, NOP_INSTR, 1'b1, XCAUSE_MISALIGNED);
        if (!if_redirect_i) begin
            if ((state == S_BUSY) && iwbm_err_i) begin
                new_valid = 1'b1;
                new_entry = make_entry(bus_addr, NOP_INSTR, 1'b1, XCAUSE_ACCESS_FAULT);
            end else if ((state == S_BUSY) && iwbm_ack_i) begin
                new_valid = 1'b1;
                new_entry = make_entry(bus_addr, iwbm_dat_i, 1'b0, 4'd0);
            end else if (misaligned_start) begin
                new_valid = 1'b1;
            end
        end
    end

    // The skid keeps program order: when it is full, IF/ID takes the skid and the new entry queues behind.
    assign skid_push = new_valid && (skid_full ? id_ready : !id_ready);
    assign skid_pop  = !if_redirect_i && id_ready && skid_full;
    assign id_next   = skid_full ? skid_entry : new_entry;

    mirfak_fetch_skid u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (if_redirect_i),
        .push     (skid_push),
        .pop      (skid_pop),
        .incoming (new_entry),
        .full     (skid_full),
        .held     (skid_entry)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_ADDR;
            bus_addr <= 32'h0;
            bus_cyc  <= 1'b0;
        end else if (if_redirect_i) begin
            fetch_pc <= if_redirect_pc_i;
            // A request still in flight must be allowed to complete before the bus is released.
            if (((state == S_BUSY) || (state == S_DISCARD)) && !bus_done) begin
                state <= S_DISCARD;
            end else begin
                state   <= S_IDLE;
                bus_cyc <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!skid_full) begin
                        if (fetch_pc[1:0] != 2'b00) begin
                            state <= S_HALT;
                        end else begin
                            state    <= S_BUSY;
                            bus_cyc  <= 1'b1;
                            bus_addr <= fetch_pc;
                        end
                    end
                end
                S_BUSY: begin
                    if (iwbm_err_i) begin
                        state   <= S_HALT;
                        bus_cyc <= 1'b0;
                    end else if (iwbm_ack_i) begin
                        state    <= S_IDLE;
                        bus_cyc  <= 1'b0;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                S_DISCARD: begin
                    if (bus_done) begin
                        state   <= S_IDLE;
                        bus_cyc <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state   <= S_IDLE;
                    bus_cyc <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_valid_o       <= 1'b0;
            id_pc_o          <= 32'h0;
            id_instruction_o <= NOP_INSTR;
            id_exception_o   <= 1'b0;
            id_xcause_o      <= 4'd0;
        end else if (if_redirect_i) begin
            id_valid_o <= 1'b0;
        end else if (id_ready) begin
            if (skid_full || new_valid) begin
                id_valid_o       <= 1'b1;
                id_pc_o          <= id_next.pc;
                id_instruction_o <= id_next.instr;
                id_exception_o   <= id_next.exc;
                id_xcause_o      <= id_next.cause;
            end else begin
                id_valid_o <= 1'b0;
            end
        end
    end

    // An entry may only enter an occupied skid when the occupant moves to IF/ID that same edge.
    assert property (@(posedge clk_i) disable iff (rst_i) (skid_push && skid_full) |-> skid_pop);
    assert property (@(posedge clk_i) disable iff (rst_i) iwbm_cyc_o |-> (iwbm_addr_o[1:0] == 2'b00));

endmodule

// File: tb/tb_mirfak_fetch_unit.sv
// Bench for mirfak_fetch_unit: directed fetch scenarios, then randomized traffic
// checked against an in-order instruction stream model.
module tb_mirfak_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] id_pc_o;
    logic [31:0] id_instruction_o;
    logic        id_valid_o;
    logic        id_exception_o;
    logic [3:0]  id_xcause_o;

    logic        bus_auto = 1'b0;
    logic        man_ack, man_err, auto_ack, auto_err;
    logic [31:0] man_dat, auto_dat;

    int total = 0;
    int bad = 0;

    assign iwbm_ack_i = bus_auto ? auto_ack : man_ack;
    assign iwbm_err_i = bus_auto ? auto_err : man_err;
    assign iwbm_dat_i = bus_auto ? auto_dat : man_dat;

    always #5 clk = ~clk;

    mirfak_fetch_unit #(.RESET_ADDR(32'h8000_0000)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .iwbm_addr_o      (iwbm_addr_o),
        .iwbm_cyc_o       (iwbm_cyc_o),
        .iwbm_stb_o       (iwbm_stb_o),
        .iwbm_dat_i       (iwbm_dat_i),
        .iwbm_ack_i       (iwbm_ack_i),
        .iwbm_err_i       (iwbm_err_i),
        .if_redirect_i    (redirect),
        .if_redirect_pc_i (redirect_pc),
        .id_stall_i       (stall),
        .id_pc_o          (id_pc_o),
        .id_instruction_o (id_instruction_o),
        .id_valid_o       (id_valid_o),
        .id_exception_o   (id_exception_o),
        .id_xcause_o      (id_xcause_o)
    );

    task automatic checkOutput(input string tag, input logic [71:0] seen, input logic [71:0] want);
        total++;
        if (seen !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, seen, want);
        end
    endtask

    // Memory contents and faulting addresses are pure functions of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F17 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return ((a >> 2) % 17) == 3;
    endfunction

    // Randomized slave used once the directed part is over.
    initial begin
        int lat_left;
        lat_left = -1;
        auto_ack = 1'b0;
        auto_err = 1'b0;
        auto_dat = 32'h0;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            auto_err = 1'b0;
            if (bus_auto && iwbm_cyc_o && !rst) begin
                if (lat_left < 0) lat_left = $urandom_range(0, 3);
                if (lat_left == 0) begin
                    if (is_err(iwbm_addr_o)) auto_err = 1'b1;
                    else auto_ack = 1'b1;
                    auto_dat = mem_word(iwbm_addr_o);
                    lat_left = -1;
                end else begin
                    lat_left--;
                end
            end else begin
                lat_left = -1;
            end
        end
    end

    initial begin
        logic        seen_req;
        logic [31:0] exp_pc;
        logic        halted;
        logic        exp_exc;
        int          idle_cycles;
        logic [71:0] want, seen;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        man_ack = 1'b0; man_err = 1'b0; man_dat = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cyc", iwbm_cyc_o, 0);
        checkOutput("rst_valid", id_valid_o, 0);
        checkOutput("rst_pc", id_pc_o, 0);
        checkOutput("rst_instr", id_instruction_o, NOP);
        checkOutput("rst_exc", {id_exception_o, id_xcause_o}, 0);

        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_addr", iwbm_addr_o, 32'h8000_0000);
        checkOutput("first_cyc_stb", {iwbm_cyc_o, iwbm_stb_o}, 2'b11);
        @(negedge clk); man_ack = 1'b1; man_dat = 32'h0000_0093;
        @(negedge clk); man_ack = 1'b0;
        checkOutput("first_entry", {id_valid_o, id_pc_o, id_instruction_o, id_exception_o},
                    {1'b1, 32'h8000_0000, 32'h0000_0093, 1'b0});
        stall = 1'b1;
        @(negedge clk);
        checkOutput("second_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0004});
        @(negedge clk); man_ack = 1'b1; man_dat = 32'h0000_0113;
        @(negedge clk); man_ack = 1'b0;
        seen_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (iwbm_cyc_o) seen_req = 1'b1;
        end
        checkOutput("skid_blocks_req", seen_req, 0);
        checkOutput("stall_hold", {id_valid_o, id_pc_o, id_instruction_o},
                    {1'b1, 32'h8000_0000, 32'h0000_0093});
        stall = 1'b0;
        @(negedge clk);
        checkOutput("skid_handoff", {id_valid_o, id_pc_o, id_instruction_o},
                    {1'b1, 32'h8000_0004, 32'h0000_0113});
        @(negedge clk);
        checkOutput("no_duplicate", id_valid_o, 0);
        checkOutput("third_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0008});

        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        @(negedge clk); redirect = 1'b0;
        checkOutput("discard_hold", {iwbm_cyc_o, iwbm_addr_o, id_valid_o}, {1'b1, 32'h8000_0008, 1'b0});
        @(negedge clk);
        @(negedge clk); man_ack = 1'b1; man_dat = 32'hDEAD_BEEF;
        @(negedge clk); man_ack = 1'b0;
        checkOutput("discard_drop", {id_valid_o, iwbm_cyc_o}, 2'b00);
        @(negedge clk);
        checkOutput("redirect_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0100});

        man_ack = 1'b1; man_dat = 32'h0000_0213;
        @(negedge clk); man_ack = 1'b0;
        checkOutput("redirect_entry", {id_valid_o, id_pc_o}, {1'b1, 32'h8000_0100});
        redirect = 1'b1; redirect_pc = 32'h8000_0102;
        @(negedge clk); redirect = 1'b0;
        checkOutput("mis_flush", {id_valid_o, iwbm_cyc_o}, 2'b00);
        @(negedge clk);
        checkOutput("mis_entry", {iwbm_cyc_o, id_valid_o, id_pc_o, id_instruction_o, id_exception_o, id_xcause_o},
                    {1'b0, 1'b1, 32'h8000_0102, NOP, 1'b1, 4'd0});
        seen_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (iwbm_cyc_o) seen_req = 1'b1;
        end
        checkOutput("mis_halt_quiet", seen_req, 0);

        redirect = 1'b1; redirect_pc = 32'h8000_0008;
        @(negedge clk); redirect = 1'b0;
        @(negedge clk);
        checkOutput("err_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0008});
        man_err = 1'b1;
        @(negedge clk); man_err = 1'b0;
        checkOutput("err_entry", {iwbm_cyc_o, id_valid_o, id_pc_o, id_instruction_o, id_exception_o, id_xcause_o},
                    {1'b0, 1'b1, 32'h8000_0008, NOP, 1'b1, 4'd1});
        seen_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (iwbm_cyc_o) seen_req = 1'b1;
        end
        checkOutput("err_halt_quiet", seen_req, 0);
        redirect = 1'b1; redirect_pc = 32'h8000_0000;
        @(negedge clk); redirect = 1'b0;
        @(negedge clk);
        checkOutput("resume_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0000});

        rst = 1'b1;
        #1;
        checkOutput("async_rst_bus", {iwbm_cyc_o, iwbm_stb_o}, 2'b00);
        man_ack = 1'b1; man_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); man_ack = 1'b0;
        checkOutput("stale_ack", id_valid_o, 0);
        checkOutput("restart_req", {iwbm_cyc_o, iwbm_addr_o}, {1'b1, 32'h8000_0000});

        bus_auto = 1'b1;
        exp_pc = 32'h0;
        halted = 1'b0;
        idle_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (iwbm_cyc_o) checkOutput("bus_align", iwbm_addr_o[1:0], 0);
            if (halted) checkOutput("halt_quiet", iwbm_cyc_o, 0);
            stall = ($urandom_range(0, 99) < 30);
            if (n == 0 || $urandom_range(0, 99) < 3) begin
                redirect = 1'b1;
                redirect_pc = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
                if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
                exp_pc = redirect_pc;
                halted = 1'b0;
                idle_cycles = 0;
            end else if (id_valid_o && !stall) begin
                idle_cycles = 0;
                if (halted) begin
                    checkOutput("entry_after_halt", id_valid_o, 0);
                end else begin
                    exp_exc = (exp_pc[1:0] != 2'b00) || is_err(exp_pc);
                    want = {exp_pc, exp_exc ? NOP : mem_word(exp_pc), exp_exc,
                            exp_exc ? ((exp_pc[1:0] != 2'b00) ? 4'd0 : 4'd1) : 4'd0};
                    seen = {id_pc_o, id_instruction_o, id_exception_o,
                            id_exception_o ? id_xcause_o : 4'd0};
                    checkOutput("stream_entry", seen, want);
                    if (exp_exc) halted = 1'b1;
                    else exp_pc = exp_pc + 32'd4;
                end
            end else if (!halted) begin
                idle_cycles++;
                if (idle_cycles > 60) begin
                    checkOutput("progress_timeout", 0, 1);
                    idle_cycles = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
